// File: rtl/nibble_serial_subtractor_if.sv
// Operand/result bus of the nibble-serial subtractor.
// The master side issues operands; the slave side returns the difference and its flags.
interface nibble_serial_subtractor_if #(
  parameter int WORDS = 4
);
  localparam int W = 4 * WORDS;

  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         bin;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic         bout;
  logic         overflow;

  modport master (
    output start, a, b, bin,
    input  busy, done, result, bout, overflow
  );

  modport slave (
    input  start, a, b, bin,
    output busy, done, result, bout, overflow
  );
endinterface

// File: rtl/nibble_serial_subtractor.sv
// Multi-precision subtractor: a - b - bin over WORDS nibbles, one 4-bit
// borrow-ripple stage per clock, least-significant nibble first.
module nibble_serial_subtractor #(
  parameter int WORDS = 4
) (
  input logic                       clk,
  input logic                       reset,
  nibble_serial_subtractor_if.slave bus
);
  localparam int W     = 4 * WORDS;
  localparam int IDX_W = $clog2(WORDS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               borrow_q, borrow_d;
  logic [W-1:0]       a_q, a_d;
  logic [W-1:0]       b_q, b_d;
  logic [W-1:0]       result_q, result_d;
  logic               bout_q, bout_d;
  logic               ovf_q, ovf_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [5:0]         nib;

  // Returns {overflow, borrow_out, diff[3:0]}; overflow is borrow into bit 3 xor borrow out of bit 3.
  function automatic logic [5:0] sub_nibble(input logic [3:0] x, input logic [3:0] y,
                                            input logic bi);
    logic [4:0] br;
    logic [3:0] d;
    br    = '0;
    br[0] = bi;
    for (int k = 0; k < 4; k++) begin
      d[k]      = x[k] ^ y[k] ^ br[k];
      br[k + 1] = (~x[k] & y[k]) | (~(x[k] ^ y[k]) & br[k]);
    end
    return {br[3] ^ br[4], br[4], d};
  endfunction

  assign nib = sub_nibble(a_q[4*idx_q +: 4], b_q[4*idx_q +: 4], borrow_q);

  always_comb begin
    // NOTE: every _d starts as a copy of its _q so no path through the case can infer a latch.
    state_d  = state_q;
    idx_d    = idx_q;
    borrow_d = borrow_q;
    a_d      = a_q;
    b_d      = b_q;
    result_d = result_q;
    bout_d   = bout_q;
    ovf_d    = ovf_q;

    case (state_q)
      IDLE, DONE: begin
        if (bus.start) begin
          state_d  = RUN;
          a_d      = bus.a;
          b_d      = bus.b;
          borrow_d = bus.bin;
          idx_d    = '0;
          result_d = '0;
          bout_d   = 1'b0;
          ovf_d    = 1'b0;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        // start is deliberately not looked at here: a running operation cannot be disturbed.
        result_d[4*idx_q +: 4] = nib[3:0];
        borrow_d               = nib[4];
        idx_d                  = idx_q + 1'b1;
        if (idx_q == LAST_IDX) begin
          state_d = DONE;
          bout_d  = nib[4];
          ovf_d   = nib[5];
          idx_d   = '0;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d == RUN);
    done_d = (state_d == DONE);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      borrow_q <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      bout_q   <= 1'b0;
      ovf_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      borrow_q <= borrow_d;
      a_q      <= a_d;
      b_q      <= b_d;
      result_q <= result_d;
      bout_q   <= bout_d;
      ovf_q    <= ovf_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.result   = result_q;
  assign bus.bout     = bout_q;
  assign bus.overflow = ovf_q;
endmodule

// File: tb/tb_nibble_serial_subtractor.sv
// Directed bench for nibble_serial_subtractor (WORDS = 4): vector table plus
// hand-written start-while-busy, mid-run reset and back-to-back sequences.
module tb_nibble_serial_subtractor;
  localparam int WORDS = 4;
  localparam int W     = 4 * WORDS;

  logic clk;
  logic reset;

  nibble_serial_subtractor_if #(.WORDS(WORDS)) bus ();

  nibble_serial_subtractor #(.WORDS(WORDS)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         bin;
    logic [W-1:0] exp_result;
    logic         exp_bout;
    logic         exp_ovf;
  } vec_t;

  // Drive start for one cycle; returns at the sampling point of the first busy cycle.
  task automatic accept(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin);
    @(negedge clk);
    bus.start = 1'b1;
    bus.a     = a;
    bus.b     = b;
    bus.bin   = bin;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  // Counts cycles from the current one (numbered n0) until done, bounded.
  task automatic wait_done(input int n0, output int lat, output int busy_n);
    lat    = n0;
    busy_n = 0;
    while (!bus.done && lat < 60) begin
      if (bus.busy) busy_n++;
      @(negedge clk);
      lat++;
    end
    if (!bus.done) begin
      errors++;
      checks++;
      $display("FAIL done_timeout: got no done, expected done within 60 cycles");
    end
  endtask

  vec_t vecs[7];

  initial begin
    int lat, busy_n, done_seen, d1, d2;

    vecs[0] = '{16'h1234, 16'h0235, 1'b0, 16'h0FFF, 1'b0, 1'b0};
    vecs[1] = '{16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0};
    vecs[2] = '{16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b1};
    vecs[3] = '{16'h7FFF, 16'hFFFF, 1'b0, 16'h8000, 1'b1, 1'b1};
    vecs[4] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0};
    vecs[5] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b0, 1'b0};
    vecs[6] = '{16'h0100, 16'h0001, 1'b1, 16'h00FE, 1'b0, 1'b0};

    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    bus.bin   = 1'b0;
    reset     = 1'b1;
    repeat (2) @(negedge clk);
    check("reset_busy", 32'(bus.busy), 32'd0);
    check("reset_done", 32'(bus.done), 32'd0);
    check("reset_result", 32'(bus.result), 32'd0);
    check("reset_flags", {30'd0, bus.bout, bus.overflow}, 32'd0);
    reset = 1'b0;

    foreach (vecs[i]) begin
      accept(vecs[i].a, vecs[i].b, vecs[i].bin);
      check($sformatf("v%0d_busy_first", i), 32'(bus.busy), 32'd1);
      wait_done(1, lat, busy_n);
      check($sformatf("v%0d_latency", i), 32'(lat), 32'd5);
      check($sformatf("v%0d_busy_cycles", i), 32'(busy_n), 32'd4);
      check($sformatf("v%0d_result", i), 32'(bus.result), 32'(vecs[i].exp_result));
      check($sformatf("v%0d_bout", i), 32'(bus.bout), 32'(vecs[i].exp_bout));
      check($sformatf("v%0d_overflow", i), 32'(bus.overflow), 32'(vecs[i].exp_ovf));
      @(negedge clk);
      check($sformatf("v%0d_done_pulse", i), {30'd0, bus.done, bus.busy}, 32'd0);
      check($sformatf("v%0d_result_hold", i), 32'(bus.result), 32'(vecs[i].exp_result));
    end

    // Start in the second busy cycle with a different minuend must be ignored.
    accept(16'h0005, 16'h0003, 1'b1);
    @(negedge clk);
    bus.start = 1'b1;
    bus.a     = 16'hFFFF;
    @(negedge clk);
    bus.start = 1'b0;
    wait_done(3, lat, busy_n);
    check("swb_latency", 32'(lat), 32'd5);
    check("swb_result", 32'(bus.result), 32'h0001);
    check("swb_bout", 32'(bus.bout), 32'd0);
    check("swb_overflow", 32'(bus.overflow), 32'd0);

    // Asynchronous reset in the second busy cycle, after nibble 0 has landed.
    accept(16'h1234, 16'h0235, 1'b0);
    @(negedge clk);
    check("rst_mid_partial", 32'(bus.result), 32'h000F);
    #2 reset = 1'b1;
    #1;
    check("rst_mid_busy", 32'(bus.busy), 32'd0);
    check("rst_mid_done", 32'(bus.done), 32'd0);
    check("rst_mid_result", 32'(bus.result), 32'd0);
    check("rst_mid_flags", {30'd0, bus.bout, bus.overflow}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    done_seen = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (bus.done || bus.busy) done_seen++;
    end
    check("rst_no_done", 32'(done_seen), 32'd0);

    // start held high across DONE: second operation accepted on the DONE edge.
    @(negedge clk);
    bus.start = 1'b1;
    bus.a     = 16'h0010;
    bus.b     = 16'h0001;
    bus.bin   = 1'b0;
    d1 = -1;
    d2 = -1;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (bus.done) begin
        if (d1 < 0) begin
          d1 = c;
          check("b2b_first_result", 32'(bus.result), 32'h000F);
          check("b2b_first_bout", 32'(bus.bout), 32'd0);
          bus.a = 16'h0003;
          bus.b = 16'h0004;
        end else if (d2 < 0) begin
          d2 = c;
          check("b2b_second_result", 32'(bus.result), 32'hFFFF);
          check("b2b_second_bout", 32'(bus.bout), 32'd1);
          bus.start = 1'b0;
        end
      end
    end
    bus.start = 1'b0;
    check("b2b_first_seen", 32'(d1 >= 0), 32'd1);
    check("b2b_spacing", 32'(d2 - d1), 32'd5);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
